// File: rtl/trigger.sv
// Ultrasonic ranging sequencer: fires a Trigger pulse, times the synchronized
// Echo high width, flags near objects on Led and pulses Done once per cycle.
module trigger #(
    parameter int unsigned TRIG_CYCLES   = 500,
    parameter int unsigned ECHO_TIMEOUT  = 1_500_000,
    parameter int unsigned LED_THRESHOLD = 29_000,
    parameter int unsigned COOLDOWN      = 3_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic Enable,
    input  logic Echo,
    output logic Trigger,
    output logic Done,
    output logic Led
);

    localparam int CW = 32;
    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(ECHO_TIMEOUT - 1);
    localparam logic [CW-1:0] TO_FULL   = CW'(ECHO_TIMEOUT);
    localparam logic [CW-1:0] NEAR_THR  = CW'(LED_THRESHOLD);
    localparam logic [CW-1:0] CD_LAST   = CW'(COOLDOWN - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_HIGH = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_DONE      = 3'd4,
        ST_COOLDOWN  = 3'd5
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   width_r;
    logic            timeout_r;
    logic            echo_meta_r;
    logic            echo_sync_r;

    // A timed-out measurement never counts as near, whatever width was latched.
    function automatic logic is_near(input logic [CW-1:0] width, input logic timeout);
        is_near = (!timeout) && (width < NEAR_THR);
    endfunction

    // Two-flop synchronizer for the asynchronous Echo line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta_r <= 1'b0;
            echo_sync_r <= 1'b0;
        end else begin
            echo_meta_r <= Echo;
            echo_sync_r <= echo_meta_r;
        end
    end

    // Measurement sequencer; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            width_r   <= {CW{1'b0}};
            timeout_r <= 1'b0;
            Trigger   <= 1'b0;
            Done      <= 1'b0;
            Led       <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (Enable) begin
                        cnt_r   <= {CW{1'b0}};
                        Trigger <= 1'b1;
                        state_r <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    if (!Enable) begin
                        Trigger <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_IDLE;
                    end else if (cnt_r == TRIG_LAST) begin
                        Trigger <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_WAIT_HIGH;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!Enable) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_IDLE;
                    end else if (echo_sync_r) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_MEASURE;
                    end else if (cnt_r == TO_LAST) begin
                        timeout_r <= 1'b1;
                        Done      <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_MEASURE: begin
                    if (!Enable) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_IDLE;
                    end else if (!echo_sync_r) begin
                        width_r   <= cnt_r;
                        timeout_r <= 1'b0;
                        Done      <= 1'b1;
                        state_r   <= ST_DONE;
                    end else if (cnt_r == TO_LAST) begin
                        width_r   <= TO_FULL;
                        timeout_r <= 1'b1;
                        Done      <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_DONE: begin
                    Led     <= is_near(width_r, timeout_r);
                    cnt_r   <= {CW{1'b0}};
                    state_r <= ST_COOLDOWN;
                end
                ST_COOLDOWN: begin
                    if (cnt_r == CD_LAST) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                default: begin
                    Trigger <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger.sv
// Directed bench for trigger with small parameters: pulse widths, Led decisions,
// timeouts, Enable abort and asynchronous reset.
module tb_trigger;

    logic clk;
    logic rst_n;
    logic Enable;
    logic Echo;
    logic Trigger;
    logic Done;
    logic Led;

    int n_checks = 0;
    int n_fail   = 0;

    trigger #(
        .TRIG_CYCLES  (5),
        .ECHO_TIMEOUT (100),
        .LED_THRESHOLD(20),
        .COOLDOWN     (10)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Enable (Enable),
        .Echo   (Echo),
        .Trigger(Trigger),
        .Done   (Done),
        .Led    (Led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Waits for Trigger to rise (gap = negedges waited) then measures its width.
    // Returns on the first negedge with Trigger low again.
    task automatic wait_trig(output int gap, output int width);
        gap   = 0;
        width = 0;
        while (!Trigger && gap < 300) begin
            @(negedge clk);
            gap++;
        end
        check("trig_seen", 32'(Trigger), 32'd1);
        while (Trigger && width < 300) begin
            @(negedge clk);
            width++;
        end
        check("trig_width", 32'(width), 32'd5);
    endtask

    // Waits for Done, checks it is a single-clock pulse; returns one negedge later.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!Done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", 32'(Done), 32'd1);
        @(negedge clk);
        check("done_pulse_len", 32'(Done), 32'd0);
    endtask

    task automatic echo_pulse(input int len);
        repeat (2) @(negedge clk);
        Echo = 1'b1;
        repeat (len) @(negedge clk);
        Echo = 1'b0;
    endtask

    initial begin
        int gap;
        int width;
        int lat;
        int dones;

        rst_n  = 1'b0;
        Enable = 1'b0;
        Echo   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_trigger", 32'(Trigger), 32'd0);
        check("rst_done",    32'(Done),    32'd0);
        check("rst_led",     32'(Led),     32'd0);

        rst_n  = 1'b1;
        Enable = 1'b1;

        // Near object: Led set, then cooldown gap before the next pulse.
        wait_trig(gap, width);
        echo_pulse(10);
        wait_done(lat);
        check("near_led", 32'(Led), 32'd1);
        wait_trig(gap, width);
        check("cooldown_gap", 32'(gap), 32'd11);

        echo_pulse(50);
        wait_done(lat);
        check("far_led", 32'(Led), 32'd0);

        wait_trig(gap, width);
        echo_pulse(10);
        wait_done(lat);
        check("near2_led", 32'(Led), 32'd1);

        // No echo at all: WAIT_HIGH times out.
        wait_trig(gap, width);
        wait_done(lat);
        check("wait_timeout_lat", 32'(lat), 32'd100);
        check("wait_timeout_led", 32'(Led), 32'd0);

        wait_trig(gap, width);
        echo_pulse(10);
        wait_done(lat);
        check("near3_led", 32'(Led), 32'd1);

        // Echo held high from WAIT_HIGH entry: MEASURE saturates.
        wait_trig(gap, width);
        Echo = 1'b1;
        wait_done(lat);
        check("meas_timeout_lat", 32'(lat), 32'd103);
        check("meas_timeout_led", 32'(Led), 32'd0);
        Echo = 1'b0;

        wait_trig(gap, width);
        echo_pulse(10);
        wait_done(lat);
        check("near4_led", 32'(Led), 32'd1);

        // Enable drops mid-TRIG.
        gap = 0;
        while (!Trigger && gap < 300) begin
            @(negedge clk);
            gap++;
        end
        check("abort_trig_seen", 32'(Trigger), 32'd1);
        @(negedge clk);
        Enable = 1'b0;
        @(negedge clk);
        check("abort_trigger_low", 32'(Trigger), 32'd0);
        dones = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (Done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_led_kept", 32'(Led), 32'd1);

        // Reset pulsed while in MEASURE.
        Enable = 1'b1;
        wait_trig(gap, width);
        repeat (2) @(negedge clk);
        Echo = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_meas_trigger", 32'(Trigger), 32'd0);
        check("rst_meas_done",    32'(Done),    32'd0);
        check("rst_meas_led",     32'(Led),     32'd0);
        Echo = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_trig(gap, width);

        // Reset mid-TRIG drops Trigger without waiting for a clock.
        gap = 0;
        while (!Trigger && gap < 300) begin
            @(negedge clk);
            gap++;
        end
        check("rst_trig_seen", 32'(Trigger), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_trig_async", 32'(Trigger), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_trig(gap, width);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trigger.md
TRIGGER -- requirements
Module: trigger

Interface
REQ-001 Parameter TRIG_CYCLES, default 500, sets the Trigger pulse width in clocks (10 us at 50 MHz).
REQ-002 Parameter ECHO_TIMEOUT, default 1_500_000, is the maximum number of clocks spent waiting for an Echo edge or an Echo high time (30 ms).
REQ-003 Parameter LED_THRESHOLD, default 29_000, is the Echo high width in clocks below which an object counts as near (about 10 cm).
REQ-004 Parameter COOLDOWN, default 3_000_000, is the number of idle clocks between measurement cycles (60 ms).
REQ-005 Port: clk, input, 1 bit, single system clock; all logic on its rising edge.
REQ-006 Port: rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 Port: Enable, input, 1 bit, high = run measurement cycles; level-sensitive.
REQ-008 Port: Echo, input, 1 bit, sensor echo line; asynchronous to clk.
REQ-009 Port: Trigger, output, 1 bit, registered trigger pulse to the sensor.
REQ-010 Port: Done, output, 1 bit, one-clock pulse at the end of every measurement cycle.
REQ-011 Port: Led, output, 1 bit, registered near-object indicator.

Function
REQ-012 Echo SHALL pass through a 2-flop synchronizer; all Echo references below mean the synchronized value (2-clock latency).
REQ-013 The FSM SHALL have states IDLE, TRIG, WAIT_HIGH, MEASURE, DONE, COOLDOWN, driven by one internal counter of at least 22 bits.
REQ-014 IDLE: when Enable=1, clear the counter and go to TRIG on the next clock; otherwise stay in IDLE.
REQ-015 TRIG: Trigger=1 for exactly TRIG_CYCLES clocks, then go to WAIT_HIGH with the counter cleared.
REQ-016 Trigger SHALL be 1 only in TRIG.
REQ-017 WAIT_HIGH: on Echo=1, clear the counter and go to MEASURE; if the counter reaches ECHO_TIMEOUT first, go to DONE with a timeout result.
REQ-018 Any Echo already high when WAIT_HIGH is entered SHALL count as the rising edge.
REQ-019 MEASURE: the counter SHALL increment each clock while Echo=1.
REQ-020 MEASURE exit on Echo=0: latch the width and go to DONE.
REQ-021 MEASURE exit at ECHO_TIMEOUT: saturate the width and go to DONE with a timeout result.
REQ-022 DONE: Done=1 for exactly one clock.
REQ-023 DONE, non-timeout result: Led SHALL update to 1 if the width < LED_THRESHOLD, else 0.
REQ-024 DONE, timeout result: Led SHALL update to 0.
REQ-025 DONE SHALL then go to COOLDOWN with the counter cleared.
REQ-026 COOLDOWN: wait COOLDOWN clocks, then go to IDLE; the cycle repeats while Enable stays high.
REQ-027 Enable=0 in TRIG, WAIT_HIGH or MEASURE SHALL abort: go to IDLE next clock, drop Trigger, no Done pulse, Led unchanged.
REQ-028 Enable=0 in DONE or COOLDOWN SHALL let the current step finish, then park in IDLE.
REQ-029 Led SHALL hold its value between updates.
REQ-030 Counter compares SHALL be unsigned; the counter SHALL never wrap.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, counter 0, synchronizer flops 0, Trigger=0, Done=0, Led=0.
REQ-032 Reset SHALL take precedence at any point in the cycle, including mid-TRIG, where Trigger drops asynchronously.
REQ-033 After rst_n deasserts, the first cycle SHALL start on the first clock edge with Enable=1.

Verification
REQ-034 Parameters TRIG_CYCLES=5, ECHO_TIMEOUT=100, LED_THRESHOLD=20, COOLDOWN=10; Enable=1 after reset -> Trigger high exactly 5 clocks, then low.
REQ-035 Echo high for 10 clocks after the trigger -> one Done pulse; Led=1; a new Trigger pulse starts after 10 COOLDOWN clocks.
REQ-036 Echo high for 50 clocks -> Done pulse; Led=0.
REQ-037 Echo never rises -> Done 100 clocks after entering WAIT_HIGH; Led=0.
REQ-038 Echo held high continuously -> MEASURE times out at 100 clocks; Done pulse; Led=0; no hang.
REQ-039 Enable drops mid-TRIG -> Trigger low on the next clock; no Done.
REQ-040 rst_n pulsed during MEASURE -> all outputs 0 immediately; with Enable=1, a fresh Trigger follows after release.
